// File: rtl/draw_pkg.sv
// Shared state encoding and default screen geometry for the draw sequencer.
package draw_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StCirc,
    StFinish
  } draw_state_e;

  localparam int unsigned DefScreenW  = 160;
  localparam int unsigned DefScreenH  = 120;
  localparam logic [2:0]  DefBgColour = 3'b000;

endpackage

// File: rtl/fill_scan.sv
// Full-screen raster scan for the clear pass: y walks the inner loop, x the outer.
module fill_scan import draw_pkg::*; #(
  parameter int unsigned SCREEN_W = DefScreenW,
  parameter int unsigned SCREEN_H = DefScreenH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       last
);

  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic       x_end, y_end;

  assign x_end = (x_q == 8'(SCREEN_W - 1));
  assign y_end = (y_q == 7'(SCREEN_H - 1));

  // Wraps to (0,0) after the final pixel so the next clear starts clean.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (enable) begin
      if (y_end) begin
        y_d = '0;
        x_d = x_end ? '0 : x_q + 8'd1;
      end else begin
        y_d = y_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_end && y_end;

endmodule

// File: rtl/draw_sequencer.sv
// Scene sequencer: optional full-screen clear, then one circle via an external
// circle engine whose pixels are registered and clipped on the way to the VGA port.
module draw_sequencer import draw_pkg::*; #(
  parameter int unsigned SCREEN_W  = DefScreenW,
  parameter int unsigned SCREEN_H  = DefScreenH,
  parameter logic [2:0]  BG_COLOUR = DefBgColour,
  parameter bit          CLEAR_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] radius,
  output logic       done,
  output logic       circ_start,
  output logic [2:0] circ_colour,
  output logic [7:0] circ_centre_x,
  output logic [6:0] circ_centre_y,
  output logic [7:0] circ_radius,
  input  logic       circ_done,
  input  logic [7:0] circ_vga_x,
  input  logic [6:0] circ_vga_y,
  input  logic [2:0] circ_vga_colour,
  input  logic       circ_vga_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  draw_state_e state_q, state_d;

  logic [2:0] colour_q;
  logic [7:0] cx_q;
  logic [6:0] cy_q;
  logic [7:0] radius_q;

  logic [7:0] pix_x_q;
  logic [6:0] pix_y_q;
  logic [2:0] pix_colour_q;
  logic       pix_plot_q;
  logic       pix_in_range;

  logic       scan_en;
  logic [7:0] scan_x;
  logic [6:0] scan_y;
  logic       scan_last;

  assign scan_en = (state_q == StClear);

  fill_scan #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_fill_scan (
    .clk   (clk),
    .rst   (rst),
    .enable(scan_en),
    .x     (scan_x),
    .y     (scan_y),
    .last  (scan_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req) state_d = CLEAR_EN ? StClear : StCirc;
      StClear:  if (scan_last) state_d = StCirc;
      StCirc:   if (circ_done) state_d = StFinish;
      StFinish: if (!req) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colour_q <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      radius_q <= '0;
    end else if (state_q == StIdle && req) begin
      colour_q <= colour;
      cx_q     <= centre_x;
      cy_q     <= centre_y;
      radius_q <= radius;
    end
  end

  // Zero-extended compare: an off-screen coordinate must never alias on-screen.
  assign pix_in_range = (32'(circ_vga_x) < SCREEN_W) && (32'(circ_vga_y) < SCREEN_H);

  // Capture only in CIRC, so the first FINISH cycle shows the last circle pixel
  // and the cycle after it shows nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_colour_q <= '0;
      pix_plot_q   <= 1'b0;
    end else begin
      pix_plot_q <= (state_q == StCirc) && circ_vga_plot && pix_in_range;
      if (state_q == StCirc) begin
        pix_x_q      <= circ_vga_x;
        pix_y_q      <= circ_vga_y;
        pix_colour_q <= circ_vga_colour;
      end
    end
  end

  always_comb begin
    done          = (state_q == StFinish);
    circ_start    = (state_q == StCirc);
    circ_colour   = colour_q;
    circ_centre_x = cx_q;
    circ_centre_y = cy_q;
    circ_radius   = radius_q;
    vga_x         = pix_x_q;
    vga_y         = pix_y_q;
    vga_colour    = pix_colour_q;
    vga_plot      = 1'b0;
    unique case (state_q)
      StClear: begin
        vga_x      = scan_x;
        vga_y      = scan_y;
        vga_colour = BG_COLOUR;
        vga_plot   = 1'b1;
      end
      StCirc, StFinish: vga_plot = pix_plot_q;
      default:          vga_plot = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: cycle-level scene model plus directed literal checks.
module tb_draw_sequencer;

  localparam int W = 160;
  localparam int H = 120;
  localparam int PhIdle   = 0;
  localparam int PhClear  = 1;
  localparam int PhCirc   = 2;
  localparam int PhFinish = 3;

  logic       clk = 1'b0;
  logic       rst, req, nc_req, circ_done;
  logic [2:0] colour;
  logic [7:0] centre_x, radius;
  logic [6:0] centre_y;
  logic [7:0] cvx;
  logic [6:0] cvy;
  logic [2:0] cvc;
  logic       cvp;

  logic       done, circ_start, vga_plot;
  logic [2:0] circ_colour, vga_colour;
  logic [7:0] circ_centre_x, circ_radius, vga_x;
  logic [6:0] circ_centre_y, vga_y;

  logic       nc_done, nc_circ_start, nc_vga_plot;
  logic [2:0] nc_circ_colour, nc_vga_colour;
  logic [7:0] nc_circ_centre_x, nc_circ_radius, nc_vga_x;
  logic [6:0] nc_circ_centre_y, nc_vga_y;

  int checks = 0;
  int errors = 0;
  int nc_plot_cnt = 0;

  always #5 clk = ~clk;

  draw_sequencer dut (
    .clk(clk), .rst(rst), .req(req), .colour(colour), .centre_x(centre_x),
    .centre_y(centre_y), .radius(radius), .done(done), .circ_start(circ_start),
    .circ_colour(circ_colour), .circ_centre_x(circ_centre_x), .circ_centre_y(circ_centre_y),
    .circ_radius(circ_radius), .circ_done(circ_done), .circ_vga_x(cvx), .circ_vga_y(cvy),
    .circ_vga_colour(cvc), .circ_vga_plot(cvp), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  draw_sequencer #(.CLEAR_EN(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .req(nc_req), .colour(colour), .centre_x(centre_x),
    .centre_y(centre_y), .radius(radius), .done(nc_done), .circ_start(nc_circ_start),
    .circ_colour(nc_circ_colour), .circ_centre_x(nc_circ_centre_x),
    .circ_centre_y(nc_circ_centre_y), .circ_radius(nc_circ_radius), .circ_done(circ_done),
    .circ_vga_x(cvx), .circ_vga_y(cvy), .circ_vga_colour(cvc), .circ_vga_plot(cvp),
    .vga_x(nc_vga_x), .vga_y(nc_vga_y), .vga_colour(nc_vga_colour), .vga_plot(nc_vga_plot)
  );

  // Scene model for the main instance: phase, linear clear index, latched
  // request and the pixel the circle engine offered on the previous cycle.
  int         m_ph, m_idx;
  logic [2:0] m_col, m_pc;
  logic [7:0] m_cx, m_r, m_px;
  logic [6:0] m_cy, m_py;
  logic       m_pv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= PhIdle; m_idx <= 0; m_col <= '0; m_cx <= '0; m_cy <= '0; m_r <= '0;
      m_pv <= 1'b0; m_px <= '0; m_py <= '0; m_pc <= '0;
    end else begin
      m_pv <= (m_ph == PhCirc) && cvp && (int'(cvx) < W) && (int'(cvy) < H);
      m_px <= cvx; m_py <= cvy; m_pc <= cvc;
      case (m_ph)
        PhIdle: if (req) begin
          m_ph <= PhClear; m_idx <= 0;
          m_col <= colour; m_cx <= centre_x; m_cy <= centre_y; m_r <= radius;
        end
        PhClear: if (m_idx == W * H - 1) m_ph <= PhCirc; else m_idx <= m_idx + 1;
        PhCirc:  if (circ_done) m_ph <= PhFinish;
        default: if (!req) m_ph <= PhIdle;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every cycle: advance to the falling edge and compare the DUT with the model.
  task automatic tick();
    logic       e_plot;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_c;
    logic       ok;
    @(negedge clk);
    if (nc_vga_plot) nc_plot_cnt++;
    e_plot = 1'b0; e_x = '0; e_y = '0; e_c = '0;
    if (m_ph == PhClear) begin
      e_plot = 1'b1; e_x = 8'(m_idx / H); e_y = 7'(m_idx % H); e_c = 3'b000;
    end else if (m_ph == PhCirc || m_ph == PhFinish) begin
      e_plot = m_pv; e_x = m_px; e_y = m_py; e_c = m_pc;
    end
    ok = (done == (m_ph == PhFinish)) && (circ_start == (m_ph == PhCirc)) &&
         (vga_plot == e_plot);
    if (e_plot) ok = ok && (vga_x == e_x) && (vga_y == e_y) && (vga_colour == e_c);
    if (m_ph == PhCirc)
      ok = ok && (circ_colour == m_col) && (circ_centre_x == m_cx) &&
           (circ_centre_y == m_cy) && (circ_radius == m_r);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL model t=%0t ph=%0d done=%b start=%b plot=%b/%b xy=%0d,%0d/%0d,%0d col=%0d/%0d",
               $time, m_ph, done, circ_start, vga_plot, e_plot, vga_x, vga_y, e_x, e_y,
               vga_colour, e_c);
    end
  endtask

  task automatic emit(input string name, input int x, input int y, input bit exp_plot);
    cvx = 8'(x); cvy = 7'(y); cvc = 3'b111; cvp = 1'b1;
    tick();
    chk(name, int'(vga_plot), int'(exp_plot));
    if (exp_plot) begin
      chk({name, "_x"}, int'(vga_x), x);
      chk({name, "_y"}, int'(vga_y), y);
    end
  endtask

  bit seen [W * H];
  int n, clr_cnt, dup, bad_col, first_x, first_y, last_x, last_y, held_plots;

  initial begin
    rst = 1'b1; req = 1'b0; nc_req = 1'b0; circ_done = 1'b0;
    colour = '0; centre_x = '0; centre_y = '0; radius = '0;
    cvx = '0; cvy = '0; cvc = '0; cvp = 1'b0;
    tick();
    chk("reset_done", int'(done), 0);
    chk("reset_start", int'(circ_start), 0);
    chk("reset_plot", int'(vga_plot), 0);
    chk("reset_nc_start", int'(nc_circ_start), 0);
    tick();
    rst = 1'b0;
    tick();

    // No-clear instance: straight to the circle engine.
    colour = 3'b101; centre_x = 8'd10; centre_y = 7'd20; radius = 8'd5; nc_req = 1'b1;
    tick();
    chk("nc_start_after_latch", int'(nc_circ_start), 1);
    chk("nc_colour", int'(nc_circ_colour), 5);
    chk("nc_cx", int'(nc_circ_centre_x), 10);
    chk("nc_cy", int'(nc_circ_centre_y), 20);
    chk("nc_r", int'(nc_circ_radius), 5);
    chk("nc_no_clear_plot", int'(nc_vga_plot), 0);
    cvx = 8'd10; cvy = 7'd10; cvc = 3'b101; cvp = 1'b1;
    tick();
    chk("nc_pix_plot", int'(nc_vga_plot), 1);
    chk("nc_pix_x", int'(nc_vga_x), 10);
    chk("nc_pix_y", int'(nc_vga_y), 10);
    chk("nc_pix_col", int'(nc_vga_colour), 5);
    cvp = 1'b0; circ_done = 1'b1;
    tick();
    chk("nc_done", int'(nc_done), 1);
    circ_done = 1'b0; nc_req = 1'b0;
    tick();
    chk("nc_done_drop", int'(nc_done), 0);
    chk("nc_total_plots", nc_plot_cnt, 1);

    // Scene A: full clear with glitches on req and circ_done, then a clipped circle.
    colour = 3'b010; centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40; req = 1'b1;
    n = 0; clr_cnt = 0; dup = 0; bad_col = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    while (!circ_start && n < 20000) begin
      tick();
      if (vga_plot && !circ_start) begin
        if (clr_cnt == 0) begin first_x = int'(vga_x); first_y = int'(vga_y); end
        last_x = int'(vga_x); last_y = int'(vga_y);
        if (vga_colour != 3'b000) bad_col++;
        if (int'(vga_x) < W && int'(vga_y) < H) begin
          if (seen[int'(vga_x) * H + int'(vga_y)]) dup++;
          seen[int'(vga_x) * H + int'(vga_y)] = 1'b1;
        end else begin
          dup++;
        end
        clr_cnt++;
      end
      circ_done = (n == 100);
      req = !(n >= 3000 && n < 3005);
      n++;
    end
    chk("a_circ_start", int'(circ_start), 1);
    chk("a_clear_count", clr_cnt, W * H);
    chk("a_clear_dups", dup, 0);
    chk("a_clear_colour", bad_col, 0);
    chk("a_first_x", first_x, 0);
    chk("a_first_y", first_y, 0);
    chk("a_last_x", last_x, 159);
    chk("a_last_y", last_y, 119);
    chk("a_circ_colour", int'(circ_colour), 2);
    chk("a_circ_cx", int'(circ_centre_x), 80);
    chk("a_circ_cy", int'(circ_centre_y), 60);
    chk("a_circ_r", int'(circ_radius), 40);

    emit("a_pix_120_60", 120, 60, 1'b1);
    emit("a_clip_199_60", 199, 60, 1'b0);
    emit("a_clip_160_0", 160, 0, 1'b0);
    emit("a_pix_159_119", 159, 119, 1'b1);
    emit("a_clip_0_120", 0, 120, 1'b0);
    emit("a_clip_50_127", 50, 127, 1'b0);
    colour = 3'b011;
    for (int i = 0; i < 300; i++) begin
      cvx = 8'($urandom_range(199, 40));
      cvy = 7'($urandom_range(127, 0));
      cvc = 3'($urandom);
      cvp = 1'($urandom);
      req = (i % 50) < 45;
      tick();
    end
    req = 1'b1;
    chk("a_colour_held", int'(circ_colour), 2);
    cvx = 8'd100; cvy = 7'd100; cvc = 3'b110; cvp = 1'b1; circ_done = 1'b1;
    tick();
    chk("a_done", int'(done), 1);
    chk("a_start_low", int'(circ_start), 0);
    chk("a_flush_plot", int'(vga_plot), 1);
    chk("a_flush_x", int'(vga_x), 100);
    chk("a_flush_y", int'(vga_y), 100);
    chk("a_flush_col", int'(vga_colour), 6);
    circ_done = 1'b0; cvx = 8'd5; cvy = 7'd5;
    tick();
    chk("a_after_flush_plot", int'(vga_plot), 0);
    held_plots = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      held_plots += int'(vga_plot);
    end
    cvp = 1'b0;
    chk("a_held_plots", held_plots, 0);
    chk("a_held_done", int'(done), 1);
    chk("a_held_start", int'(circ_start), 0);
    req = 1'b0;
    tick();
    chk("a_done_drop", int'(done), 0);
    chk("a_idle_plot", int'(vga_plot), 0);

    // Scene B: new colour, reset mid-clear and mid-circle.
    req = 1'b1;
    repeat (5001) tick();
    chk("b_px5000_plot", int'(vga_plot), 1);
    chk("b_px5000_x", int'(vga_x), 41);
    chk("b_px5000_y", int'(vga_y), 80);
    #1 rst = 1'b1;
    #1;
    chk("b_async_plot", int'(vga_plot), 0);
    chk("b_async_x", int'(vga_x), 0);
    chk("b_async_y", int'(vga_y), 0);
    chk("b_async_done", int'(done), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("b_restart_x", int'(vga_x), 0);
    chk("b_restart_y", int'(vga_y), 0);
    chk("b_restart_plot", int'(vga_plot), 1);
    tick();
    chk("b_restart_y1", int'(vga_y), 1);
    n = 0;
    while (!circ_start && n < 20000) begin
      tick();
      n++;
    end
    chk("b_circ_start", int'(circ_start), 1);
    chk("b_circ_colour", int'(circ_colour), 3);
    for (int i = 0; i < 20; i++) begin
      cvx = 8'($urandom_range(199, 0));
      cvy = 7'($urandom_range(127, 0));
      cvc = 3'($urandom);
      cvp = 1'b1;
      tick();
    end
    #1 rst = 1'b1;
    #1;
    chk("b_async2_start", int'(circ_start), 0);
    chk("b_async2_plot", int'(vga_plot), 0);
    chk("b_async2_done", int'(done), 0);
    chk("b_async2_colour", int'(circ_colour), 0);
    chk("b_async2_x", int'(vga_x), 0);
    cvp = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("b_restart2_x", int'(vga_x), 0);
    chk("b_restart2_y", int'(vga_y), 0);
    chk("b_restart2_plot", int'(vga_plot), 1);
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 Parameter SCREEN_W, default 160, meaning: visible columns; a pixel with x >= SCREEN_W SHALL be clipped.
REQ-002 Parameter SCREEN_H, default 120, meaning: visible rows; a pixel with y >= SCREEN_H SHALL be clipped.
REQ-003 Parameter BG_COLOUR, default 3'b000, meaning: colour used for the screen clear.
REQ-004 Parameter CLEAR_EN, default 1, meaning: 1 = clear the screen before every circle; 0 = skip the clear.
REQ-005 Port clk, input, 1 bit: the only clock; every register SHALL use its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port req, input, 1 bit: draw request, held high by the requester until done is seen.
REQ-008 Port colour, input, 3 bits: circle colour.
REQ-009 Port centre_x, input, 8 bits: circle centre column.
REQ-010 Port centre_y, input, 7 bits: circle centre row.
REQ-011 Port radius, input, 8 bits: circle radius.
REQ-012 Port done, output, 1 bit: the scene is complete.
REQ-013 Ports circ_start (output, 1 bit), circ_colour (output, 3 bits), circ_centre_x (output, 8 bits), circ_centre_y (output, 7 bits), circ_radius (output, 8 bits): drive the circle engine.
REQ-014 Ports circ_done (input, 1 bit), circ_vga_x (input, 8 bits), circ_vga_y (input, 7 bits), circ_vga_colour (input, 3 bits), circ_vga_plot (input, 1 bit): received from the circle engine.
REQ-015 Ports vga_x (output, 8 bits), vga_y (output, 7 bits), vga_colour (output, 3 bits), vga_plot (output, 1 bit): drive the VGA adapter.

Function
REQ-016 States SHALL be IDLE, CLEAR, CIRC, FINISH.
REQ-017 IDLE: when req=1, the block SHALL latch colour, centre_x, centre_y and radius, then go to CLEAR (CLEAR_EN=1) or CIRC (CLEAR_EN=0).
REQ-018 Changes to the request inputs after the latch SHALL be ignored until the next IDLE.
REQ-019 CLEAR SHALL plot one BG_COLOUR pixel per cycle.
  - Order: y inner (0..SCREEN_H-1), x outer (0..SCREEN_W-1).
  - Total: exactly SCREEN_W*SCREEN_H plots, i.e. 19200 at the defaults.
  - Exit: to CIRC on the cycle after pixel (159,119) is issued.
REQ-020 CIRC: circ_start SHALL be 1 and the circ_* parameter outputs SHALL carry the latched values.
REQ-021 CIRC SHALL exit to FINISH on the first cycle with circ_done=1.
REQ-022 During CIRC, vga_* SHALL be a one-cycle registered copy of circ_vga_*.
REQ-023 During CIRC, vga_plot SHALL be forced to 0 when circ_vga_x >= SCREEN_W or circ_vga_y >= SCREEN_H.
REQ-024 Clipping SHALL compare the full input widths; no wrap-around of coordinates is permitted.
REQ-025 FINISH: done=1 and circ_start=0.
REQ-026 FINISH: one further cycle of pass-through SHALL flush the final registered pixel; after that cycle vga_plot SHALL be 0.
REQ-027 FINISH SHALL return to IDLE when req=0, with done=0 from that cycle on.
REQ-028 req dropping during CLEAR or CIRC SHALL be ignored; the sequence SHALL complete.
REQ-029 circ_done=1 outside CIRC SHALL be ignored.
REQ-030 vga_plot SHALL be 0 in IDLE.
REQ-031 vga_plot SHALL never be 1 for the clear and for circle pixels in the same cycle.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, with no clock edge required.
REQ-033 rst=1 SHALL immediately force done, circ_start, vga_plot and all counters to 0.
REQ-034 rst=1 SHALL immediately force all coordinate, colour and latched registers to 0.
REQ-035 After rst falls, a held req SHALL start a fresh sequence from the beginning of the clear.

Structure
REQ-036 Package draw_pkg SHALL hold the state enum, SCREEN_W/SCREEN_H defaults and BG_COLOUR default.
REQ-037 The clear scan SHALL be a sub-module fill_scan.
  - Inputs: clk, rst, enable.
  - Outputs: x (8 bits), y (7 bits), last.
  - Instantiated once.

Verification
REQ-038 Scenario: req=1, centre (80,60), r=40, colour 3'b010, circle model responds.
  - Exactly 19200 plots of 3'b000 are emitted, covering every (x,y) once.
  - circ_start then rises.
  - done=1 one cycle after circ_done.
REQ-039 Scenario: centre_x=159, r=40; model emits x up to 199.
  - No vga_plot with x >= 160.
  - In-range pixels are passed unchanged, with one-cycle latency.
REQ-040 Scenario: CLEAR_EN=0.
  - circ_start=1 on the cycle after req is latched.
  - Zero clear plots.
REQ-041 Scenario: rst pulsed at clear pixel 5000 and again mid-CIRC.
  - Outputs are 0 asynchronously.
  - After release, the clear restarts at (0,0).
REQ-042 Scenario: colour changed to 3'b011 during CIRC.
  - circ_colour stays 3'b010.
  - A second req after done/req-low handshake draws with 3'b011.
REQ-043 Scenario: req held after done.
  - done stays 1 and no new clear starts.
  - Dropping req gives done=0 next cycle and state IDLE.
